// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, valid/ready fabric side.
// RX FIFO is first-word-fall-through; error flags are sticky.
module uart_fifo_core #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_busy,
    output logic                        txd,
    input  logic                        rxd,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        rx_overrun,
    output logic                        rx_frame_err,
    output logic                        rx_parity_err,
    input  logic                        err_clear
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    // assert asynchronously, release on a clock edge
    logic [1:0] rst_sync_q;
    logic       rst_ni;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ni = rst_sync_q[1];

    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]         tx_wp_q, tx_rp_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    state_e               tx_st_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [2:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q, txd_q;

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) &&
                      (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
    assign tx_push  = tx_valid && !tx_full;
    assign tx_pop   = !tx_empty && ((tx_st_q == S_IDLE) ||
                      (tx_st_q == S_STOP && tx_cnt_q == STOP_END));
    assign tx_head  = tx_mem[tx_rp_q[TAW-1:0]];
    assign tx_ready = !tx_full;
    assign tx_busy  = !tx_empty || (tx_st_q != S_IDLE);
    assign txd      = txd_q;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_pop) begin
                tx_sh_q  <= tx_head;
                tx_par_q <= (^tx_head) ^ PAR_ODD;
            end
            unique case (tx_st_q)
                S_IDLE: begin
                    tx_cnt_q <= '0;
                    if (tx_pop) begin
                        tx_st_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= '0;
                    tx_st_q  <= S_DATA;
                    txd_q    <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                end
                S_DATA: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_st_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        txd_q   <= (PARITY != 0) ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 1'b1;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                    end
                end
                S_PAR: if (tx_cnt_q == BIT_END) begin
                    tx_cnt_q <= '0;
                    tx_st_q  <= S_STOP;
                    txd_q    <= 1'b1;
                end
                S_STOP: if (tx_cnt_q == STOP_END) begin
                    tx_cnt_q <= '0;
                    tx_st_q  <= tx_pop ? S_START : S_IDLE;
                    txd_q    <= !tx_pop;
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_e               rx_st_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [2:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q, rx_word_q;
    logic                 rx_pbad_q, rx_done_q, pe_set_q, fe_set_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_word_q <= '0;
            rx_pbad_q <= 1'b0;
            rx_done_q <= 1'b0;
            pe_set_q  <= 1'b0;
            fe_set_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_cnt_q  <= rx_cnt_q + 1'b1;
            rx_done_q <= 1'b0;
            pe_set_q  <= 1'b0;
            fe_set_q  <= 1'b0;
            unique case (rx_st_q)
                // a held-low line after a bad stop bit never forms an edge
                S_IDLE: begin
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                    rx_pbad_q <= 1'b0;
                    if (rx_prev_q && !rx_s2_q) rx_st_q <= S_START;
                end
                S_START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT)
                        rx_st_q <= (PARITY != 0) ? S_PAR : S_STOP;
                    else
                        rx_bit_q <= rx_bit_q + 1'b1;
                end
                S_PAR: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q  <= '0;
                    rx_pbad_q <= rx_s2_q != ((^rx_sh_q) ^ PAR_ODD);
                    rx_st_q   <= S_STOP;
                end
                S_STOP: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q  <= '0;
                    rx_done_q <= 1'b1;
                    rx_word_q <= rx_sh_q;
                    pe_set_q  <= rx_pbad_q;
                    fe_set_q  <= !rx_s2_q;
                    rx_st_q   <= S_IDLE;
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]         rx_wp_q, rx_rp_q;
    logic                 rx_empty, rx_full, rx_pop, rx_wr, ovr_set;
    logic                 ovr_q, fe_q, pe_q;

    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) &&
                      (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_wr    = rx_done_q && (!rx_full || rx_pop);
    assign ovr_set  = rx_done_q && rx_full && !rx_pop;
    assign rx_data  = rx_mem[rx_rp_q[RAW-1:0]];
    assign rx_level = rx_wp_q - rx_rp_q;

    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = fe_q;
    assign rx_parity_err = pe_q;

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp_q[RAW-1:0]] <= rx_word_q;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
            ovr_q <= ovr_set  || (ovr_q && !err_clear);
            fe_q  <= fe_set_q || (fe_q && !err_clear);
            pe_q  <= pe_set_q || (pe_q && !err_clear);
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: TX waveform, loopback, overrun, RX errors, glitch, reset.
// u0: no parity, 4-deep RX; u1: even parity loopback; u2: odd parity RX.
module tb_uart_fifo_core;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;

    logic [7:0] tx_data0, tx_data1, tx_data2;
    logic       tx_valid0, tx_valid1, tx_valid2;
    logic       tx_ready0, tx_ready1, tx_ready2;
    logic       tx_busy0, tx_busy1, tx_busy2;
    logic       txd0, txd1, txd2;
    logic       rxd0, rxd1, rxd2;
    logic [7:0] rx_data0, rx_data1, rx_data2;
    logic       rx_valid0, rx_valid1, rx_valid2;
    logic       rx_ready0, rx_ready1, rx_ready2;
    logic [2:0] rx_level0;
    logic [4:0] rx_level1, rx_level2;
    logic       ovr0, ovr1, ovr2, fe0, fe1, fe2, pe0, pe1, pe2;
    logic       clr;
    logic       lb0, sel2, rxd_drv;

    assign rxd0 = lb0 ? txd0 : (sel2 ? 1'b1 : rxd_drv);
    assign rxd1 = txd1;
    assign rxd2 = sel2 ? rxd_drv : 1'b1;

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .PARITY(0), .RX_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .tx_busy(tx_busy0), .txd(txd0),
        .rxd(rxd0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .rx_level(rx_level0),
        .rx_overrun(ovr0), .rx_frame_err(fe0), .rx_parity_err(pe0),
        .err_clear(clr)
    );

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_busy(tx_busy1), .txd(txd1),
        .rxd(rxd1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .rx_level(rx_level1),
        .rx_overrun(ovr1), .rx_frame_err(fe1), .rx_parity_err(pe1),
        .err_clear(clr)
    );

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .PARITY(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_busy(tx_busy2), .txd(txd2),
        .rxd(rxd2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_ready(rx_ready2), .rx_level(rx_level2),
        .rx_overrun(ovr2), .rx_frame_err(fe2), .rx_parity_err(pe2),
        .err_clear(clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d);
        tx_data0  = d;
        tx_valid0 = 1'b1;
        tick;
        tx_valid0 = 1'b0;
    endtask

    task automatic pop(input int d);
        rx_ready0 = (d == 0);
        rx_ready1 = (d == 1);
        rx_ready2 = (d == 2);
        tick;
        rx_ready0 = 1'b0;
        rx_ready1 = 1'b0;
        rx_ready2 = 1'b0;
    endtask

    function automatic logic rxv(input int d);
        return (d == 0) ? rx_valid0 : (d == 1) ? rx_valid1 : rx_valid2;
    endfunction

    task automatic wait_rx(input int d, input string tag);
        int n = 0;
        while (!rxv(d) && n < 400) begin
            tick;
            n++;
        end
        check({tag, "_wait"}, 32'(rxv(d)), 1);
    endtask

    // called one cycle after the push edge into an idle, empty u0
    task automatic tx_frame0(input logic [7:0] d, input string tag);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        check({tag, "_lead"}, 32'(txd0), 1);
        check({tag, "_busy1"}, 32'(tx_busy0), 1);
        tick;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s_b%0d", tag, b), 32'(txd0), 32'(bits[b]));
                tick;
            end
        end
        check({tag, "_busy0"}, 32'(tx_busy0), 0);
        check({tag, "_idle"}, 32'(txd0), 1);
    endtask

    task automatic send(input logic [7:0] d, input bit use_par,
                        input logic pb, input logic stop);
        rxd_drv = 1'b0;
        repeat (CPB) tick;
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (CPB) tick;
        end
        if (use_par) begin
            rxd_drv = pb;
            repeat (CPB) tick;
        end
        rxd_drv = stop;
        repeat (2 * CPB) tick;
        rxd_drv = 1'b1;
        repeat (CPB) tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ovw [5];
        int n;
        ovw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
        tx_valid0 = 0; tx_valid1 = 0; tx_valid2 = 0;
        rx_ready0 = 0; rx_ready1 = 0; rx_ready2 = 0;
        clr = 0; lb0 = 1; sel2 = 0; rxd_drv = 1;
        repeat (3) tick;
        check("rst_txd0", 32'(txd0), 1);
        check("rst_rdy0", 32'(tx_ready0), 1);
        check("rst_busy0", 32'(tx_busy0), 0);
        check("rst_rxv0", 32'(rx_valid0), 0);
        check("rst_lvl0", 32'(rx_level0), 0);
        check("rst_flags0", {29'd0, ovr0, fe0, pe0}, 0);
        check("rst_txd1", 32'(txd1), 1);
        check("rst_rdy1", 32'(tx_ready1), 1);
        check("rst_busy1", 32'(tx_busy1), 0);
        check("rst_tx2", {29'd0, txd2, tx_ready2, tx_busy2}, 3'b110);
        check("rst_lvl2", 32'(rx_level2), 0);
        check("rst_ovr2", 32'(ovr2), 0);
        rst_n = 1;
        repeat (4) tick;

        push0(8'hA5);
        tx_frame0(8'hA5, "txA5");
        wait_rx(0, "lbA5");
        check("lbA5_data", 32'(rx_data0), 32'hA5);
        check("lbA5_fe", 32'(fe0), 0);
        pop(0);

        tx_valid0 = 1;
        for (int i = 0; i < 5; i++) begin
            tx_data0 = ovw[i];
            tick;
        end
        tx_valid0 = 0;
        n = 0;
        while (tx_busy0 && n < 2000) begin
            tick;
            n++;
        end
        check("ovr_txdone", 32'(tx_busy0), 0);
        repeat (4) tick;
        check("ovr_lvl", 32'(rx_level0), 4);
        check("ovr_flag", 32'(ovr0), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_pop%0d", i), 32'(rx_data0), 32'(ovw[i]));
            pop(0);
        end
        check("ovr_empty", 32'(rx_valid0), 0);
        check("ovr_sticky", 32'(ovr0), 1);
        pop(0);
        check("pop_empty_lvl", 32'(rx_level0), 0);
        clr = 1;
        tick;
        clr = 0;
        tick;
        check("ovr_clr", 32'(ovr0), 0);

        lb0 = 0;
        send(8'h3C, 0, 1'b0, 1'b0);
        wait_rx(0, "fe");
        check("fe_data", 32'(rx_data0), 32'h3C);
        check("fe_flag", 32'(fe0), 1);
        check("fe_pe", 32'(pe0), 0);
        pop(0);
        repeat (200) tick;
        check("fe_norescan", 32'(rx_valid0), 0);
        clr = 1;
        tick;
        clr = 0;
        tick;
        check("fe_clr", 32'(fe0), 0);

        sel2 = 1;
        repeat (4) tick;
        rxd_drv = 0;
        repeat (5) tick;
        rxd_drv = 1;
        repeat (60) tick;
        check("gl_rxv", 32'(rx_valid2), 0);
        check("gl_flags", {30'd0, fe2, pe2}, 0);
        send(8'h01, 1, 1'b0, 1'b1);
        wait_rx(2, "pok");
        check("pok_data", 32'(rx_data2), 32'h01);
        check("pok_pe", 32'(pe2), 0);
        pop(2);
        send(8'h5A, 1, 1'b0, 1'b1);
        wait_rx(2, "pbad");
        check("pbad_data", 32'(rx_data2), 32'h5A);
        check("pbad_pe", 32'(pe2), 1);
        check("pbad_fe", 32'(fe2), 0);
        pop(2);
        sel2 = 0;

        tx_valid1 = 1;
        tx_data1 = 8'h00; tick;
        tx_data1 = 8'hFF; tick;
        tx_data1 = 8'h3C; tick;
        tx_valid1 = 0;
        n = 0;
        while (tx_busy1 && n < 2000) begin
            tick;
            n++;
        end
        check("lb_len", n, 527);
        repeat (4) tick;
        check("lb_lvl", 32'(rx_level1), 3);
        check("lb_flags", {29'd0, ovr1, fe1, pe1}, 0);
        check("lb_d0", 32'(rx_data1), 32'h00);
        pop(1);
        check("lb_d1", 32'(rx_data1), 32'hFF);
        pop(1);
        check("lb_d2", 32'(rx_data1), 32'h3C);
        pop(1);
        check("lb_empty", 32'(rx_valid1), 0);

        lb0 = 1;
        tx_data0 = 8'h00;
        tx_valid0 = 1;
        tick;
        tick;
        tx_valid0 = 0;
        repeat (68) tick;
        check("mid_bit3", 32'(txd0), 0);
        #2 rst_n = 0;
        #1;
        check("mid_rst_txd", 32'(txd0), 1);
        check("mid_rst_busy", 32'(tx_busy0), 0);
        tick;
        rst_n = 1;
        repeat (4) tick;
        check("post_txd", 32'(txd0), 1);
        check("post_busy", 32'(tx_busy0), 0);
        check("post_rxv", 32'(rx_valid0), 0);
        push0(8'h55);
        tx_frame0(8'h55, "tx55");
        wait_rx(0, "lb55");
        check("lb55_data", 32'(rx_data0), 32'h55);
        check("lb55_lvl", 32'(rx_level0), 1);
        repeat (40) tick;
        check("no_stale", {30'd0, tx_busy0, txd0}, 2'b01);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
